gb_irq_ctrl: RTL and testbench

Parametrised interrupt controller for the Game Boy core. It replaces the fixed 5-source IF/IE logic in the top level with a generic N-source block. Each source has a configurable edge polarity. The block provides a latched-vector acknowledge handshake so the flag being cleared always matches the vector the CPU fetched. It sits between the peripheral event lines (vblank, LCD STAT, timer, serial, joypad) and the CPU `INT_n`/`DI` path.

---
 rtl/gb_irq_ctrl.sv | 129 ++++++++++++
 tb/tb_gb_irq_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/gb_irq_ctrl.sv
// rtl/gb_irq_ctrl.sv - N-source interrupt controller with latched-vector acknowledge (optional GB_IRQ_SYNC_EN input synchroniser)
module gb_irq_ctrl #(
    parameter int          NUM_SRC    = 5,
    parameter logic [7:0]  SRC_POL    = 8'b0000_1111,
    parameter logic [7:0]  VEC_BASE   = 8'h40,
    parameter logic [7:0]  VEC_STRIDE = 8'h08,
    parameter logic [7:0]  IDLE_VEC   = 8'h55
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic               cpu_sel_ie,
    input  logic               cpu_sel_if,
    input  logic               cpu_wr,
    input  logic [7:0]         cpu_di,
    output logic [7:0]         cpu_do,
    input  logic               irq_ack,
    output logic               irq_n,
    output logic [7:0]         irq_vec
);

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t             state_q;
    logic [NUM_SRC-1:0] ie_q, if_q, if_d, src_q, src_det, evt, pend;
    logic               ack_q, ack_rise, ack_fall;
    logic               lat_valid_q;
    logic [2:0]         lat_idx_q, win_idx;
    logic               win_valid;
    logic [7:0]         unused_di;

    assign unused_di = cpu_di;

`ifdef GB_IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;
    assign src_det = sync2_q;
`else
    assign src_det = src;
`endif

    function automatic logic [7:0] vec_of(input logic [2:0] idx);
        return VEC_BASE + ({5'b0, idx} * VEC_STRIDE);
    endfunction

    always_comb begin
        evt = '0;
        for (int i = 0; i < NUM_SRC; i++)
            evt[i] = SRC_POL[i] ? (src_det[i] & ~src_q[i]) : (~src_det[i] & src_q[i]);
    end

    assign pend     = ie_q & if_q;
    assign irq_n    = ~|pend;
    assign ack_rise = irq_ack & ~ack_q;
    assign ack_fall = ~irq_ack & ack_q;

    // Lowest set index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        win_valid = |pend;
        win_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (pend[i]) win_idx = 3'(i);
    end

    always_comb begin
        if (state_q == S_ACK)
            irq_vec = lat_valid_q ? vec_of(lat_idx_q) : IDLE_VEC;
        else
            irq_vec = win_valid ? vec_of(win_idx) : IDLE_VEC;
    end

    // CPU write first, then the ack clear, then events: a hardware event is never lost.
    always_comb begin
        if_d = (cpu_sel_if && cpu_wr) ? cpu_di[NUM_SRC-1:0] : if_q;
        if (state_q == S_ACK && ack_fall && lat_valid_q) begin
            for (int i = 0; i < NUM_SRC; i++)
                if (lat_idx_q == 3'(i)) if_d[i] = 1'b0;
        end
        if_d = if_d | evt;
    end

    always_comb begin
        cpu_do = 8'hFF;
        if (cpu_sel_ie) begin
            cpu_do              = 8'h00;
            cpu_do[NUM_SRC-1:0] = ie_q;
        end else if (cpu_sel_if) begin
            cpu_do[NUM_SRC-1:0] = if_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ie_q        <= '0;
            if_q        <= '0;
            src_q       <= '0;
            ack_q       <= 1'b0;
            lat_valid_q <= 1'b0;
            lat_idx_q   <= '0;
`ifdef GB_IRQ_SYNC_EN
            sync1_q     <= '0;
            sync2_q     <= '0;
`endif
        end else begin
`ifdef GB_IRQ_SYNC_EN
            sync1_q     <= src;
            sync2_q     <= sync1_q;
`endif
            src_q       <= src_det;
            ack_q       <= irq_ack;
            if_q        <= if_d;
            if (cpu_sel_ie && cpu_wr)
                ie_q <= cpu_di[NUM_SRC-1:0];
            case (state_q)
                S_IDLE: if (ack_rise) begin
                    state_q     <= S_ACK;
                    lat_valid_q <= win_valid;
                    lat_idx_q   <= win_idx;
                end
                S_ACK: if (ack_fall) begin
                    state_q     <= S_IDLE;
                    lat_valid_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// tb/tb_gb_irq_ctrl.sv - directed table-driven bench for gb_irq_ctrl (default build)
module tb_gb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] src;
    logic       cpu_sel_ie, cpu_sel_if, cpu_wr, irq_ack;
    logic [7:0] cpu_di, cpu_do, irq_vec;
    logic       irq_n;

    int n_cmp  = 0;
    int n_fail = 0;

    gb_irq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .src        (src),
        .cpu_sel_ie (cpu_sel_ie),
        .cpu_sel_if (cpu_sel_if),
        .cpu_wr     (cpu_wr),
        .cpu_di     (cpu_di),
        .cpu_do     (cpu_do),
        .irq_ack    (irq_ack),
        .irq_n      (irq_n),
        .irq_vec    (irq_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] src;
        logic       sel_ie;
        logic       sel_if;
        logic       wr;
        logic [7:0] di;
        logic       exp_irq_n;
        logic [7:0] exp_vec;
        logic [7:0] exp_do;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] s, input logic sie, input logic sif,
                         input logic w, input logic [7:0] d, input logic a);
        src = s; cpu_sel_ie = sie; cpu_sel_if = sif; cpu_wr = w; cpu_di = d; irq_ack = a;
    endtask

    task automatic edge_then_sample;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic en, input logic [7:0] ev, input logic [7:0] ed);
        chk({tag, ".irq_n"}, {7'b0, irq_n}, {7'b0, en});
        chk({tag, ".vec"}, irq_vec, ev);
        chk({tag, ".do"}, cpu_do, ed);
    endtask

    initial begin
        //              src       ie  if  wr  di      irq_n vec    do
        tbl[0]  = '{5'b00000, 1, 0, 1, 8'h1F, 1, 8'h55, 8'h1F}; // IE = 1F
        tbl[1]  = '{5'b00100, 0, 0, 0, 8'h00, 0, 8'h50, 8'hFF}; // src2 rise
        tbl[2]  = '{5'b00000, 0, 1, 0, 8'h00, 0, 8'h50, 8'hE4}; // IF readback
        tbl[3]  = '{5'b00000, 0, 1, 1, 8'h00, 1, 8'h55, 8'hE0};
        tbl[4]  = '{5'b10000, 0, 0, 0, 8'h00, 1, 8'h55, 8'hFF}; // src4 rise: ignored
        tbl[5]  = '{5'b00000, 0, 1, 0, 8'h00, 0, 8'h60, 8'hF0}; // src4 fall: sets
        tbl[6]  = '{5'b00000, 0, 1, 1, 8'h00, 1, 8'h55, 8'hE0};
        tbl[7]  = '{5'b00001, 0, 1, 1, 8'h00, 0, 8'h40, 8'hE1}; // event beats write 0
        tbl[8]  = '{5'b00000, 0, 1, 1, 8'h00, 1, 8'h55, 8'hE0};
        tbl[9]  = '{5'b00000, 1, 0, 1, 8'h00, 1, 8'h55, 8'h00}; // IE = 0
        tbl[10] = '{5'b00010, 0, 1, 0, 8'h00, 1, 8'h55, 8'hE2}; // masked flag
        tbl[11] = '{5'b00000, 1, 0, 1, 8'h1F, 0, 8'h48, 8'h1F};
        tbl[12] = '{5'b00000, 0, 1, 1, 8'h00, 1, 8'h55, 8'hE0};

        reset = 1'b1;
        drive(5'b0, 0, 0, 0, 8'h00, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b1, 8'h55, 8'hFF);
        cpu_sel_ie = 1'b1; #1;
        chk("reset.ie", cpu_do, 8'h00);
        cpu_sel_ie = 1'b0; cpu_sel_if = 1'b1; #1;
        chk("reset.if", cpu_do, 8'hE0);
        @(negedge clk);
        reset = 1'b0;
        drive(5'b0, 0, 0, 0, 8'h00, 0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i].src, tbl[i].sel_ie, tbl[i].sel_if, tbl[i].wr, tbl[i].di, 1'b0);
            edge_then_sample();
            check_all($sformatf("row%0d", i), tbl[i].exp_irq_n, tbl[i].exp_vec, tbl[i].exp_do);
        end

        // Latched vector holds through the ack even when a higher-priority source fires.
        @(negedge clk); drive(5'b0, 0, 1, 1, 8'h0A, 0);
        edge_then_sample();
        check_all("ackA.setup", 1'b0, 8'h48, 8'hEA);
        @(negedge clk); drive(5'b0, 0, 1, 0, 8'h00, 1);
        #1 chk("ackA.rise_live", irq_vec, 8'h48);
        edge_then_sample();
        chk("ackA.c1", irq_vec, 8'h48);
        @(negedge clk); src = 5'b00001;
        edge_then_sample();
        chk("ackA.c2", irq_vec, 8'h48);
        chk("ackA.c2_if", cpu_do, 8'hEB);
        @(negedge clk); src = 5'b00000;
        edge_then_sample();
        chk("ackA.c3", irq_vec, 8'h48);
        @(negedge clk); irq_ack = 1'b0;
        edge_then_sample();
        check_all("ackA.release", 1'b0, 8'h40, 8'hE9);
        @(negedge clk); drive(5'b0, 0, 1, 1, 8'h00, 0);
        edge_then_sample();

        // Ack with nothing enabled: idle vector, no clear.
        @(negedge clk); drive(5'b0, 1, 0, 1, 8'h00, 0);
        edge_then_sample();
        @(negedge clk); drive(5'b0, 0, 1, 1, 8'h1F, 0);
        edge_then_sample();
        @(negedge clk); drive(5'b0, 0, 1, 0, 8'h00, 1);
        for (int c = 0; c < 2; c++) begin
            edge_then_sample();
            check_all($sformatf("ackB.c%0d", c), 1'b1, 8'h55, 8'hFF);
        end
        @(negedge clk); irq_ack = 1'b0;
        edge_then_sample();
        check_all("ackB.release", 1'b1, 8'h55, 8'hFF);

        // Reset in the middle of an ack.
        @(negedge clk); drive(5'b0, 1, 0, 1, 8'h1F, 0);
        edge_then_sample();
        @(negedge clk); drive(5'b0, 0, 1, 0, 8'h00, 1);
        edge_then_sample();
        check_all("ackC.in_ack", 1'b0, 8'h40, 8'hFF);
        #2 reset = 1'b1;
        #1 check_all("ackC.async_rst", 1'b1, 8'h55, 8'hE0);
        @(negedge clk); reset = 1'b0;
        edge_then_sample();
        check_all("ackC.after_rst", 1'b1, 8'h55, 8'hE0);
        @(negedge clk); irq_ack = 1'b0;
        edge_then_sample();
        check_all("ackC.release", 1'b1, 8'h55, 8'hE0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
